mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the instruction-fetch (IF) requester and
//  the load/store data (D) requester of the rv32i core.

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter_pick.sv | 16 +
 rtl/mem_port_arbiter.sv | 86 ++++++++
 tb/tb_mem_port_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/D memory port arbiter: FSM state and transaction owner.
// Default sizing matches the rv32i core (32-bit address/data).
package mem_port_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;
    typedef enum logic {OWN_IF, OWN_D}      arb_owner_e;

    localparam int ARB_ADDR_W     = 32;
    localparam int ARB_DATA_W     = 32;
    localparam int ARB_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, D requester and memory-side signals of the arbiter.
// slave = arbiter view, master = environment view (requesters plus memory).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  arb_err;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output arb_err
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  arb_err
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner select between IF and D requesters: D has priority unless IF is being starved.
// Latency: combinational. Backpressure: none here; the caller gates with mem_gnt.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       starve,
    output logic       pick_valid,
    output arb_owner_e pick_owner
);

    assign pick_valid = if_req | d_req;
    assign pick_owner = (d_req && !(if_req && starve)) ? OWN_D : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and D requesters, one transaction in flight.
// Latency: grant same cycle as mem_gnt, response same cycle as mem_rvalid; issue spacing >= 2 cycles.
// Backpressure: mem_gnt=0 holds mem_req asserted and re-arbitrates every cycle; no grant while waiting.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e    state;
    arb_owner_e    owner;
    arb_owner_e    pick_owner;
    logic [SW-1:0] streak;
    logic          arb_err_q;
    logic          pick_valid;
    logic          starve;
    logic          issue;
    logic          pick_d;
    logic          waiting;

    assign starve = (streak == SW'(STARVE_MAX));

    mem_arb_pick u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .starve     (starve),
        .pick_valid (pick_valid),
        .pick_owner (pick_owner)
    );

    assign issue   = (state == ARB_IDLE) && pick_valid;
    assign waiting = (state == ARB_WAIT);
    assign pick_d  = (pick_owner == OWN_D);

    // Memory fields are zeroed whenever nothing is being offered.
    assign bus.mem_req   = issue;
    assign bus.mem_we    = issue && pick_d && bus.d_we;
    assign bus.mem_addr  = !issue ? '0 : (pick_d ? bus.d_addr : bus.if_addr);
    assign bus.mem_wdata = (issue && pick_d) ? bus.d_wdata : '0;
    assign bus.mem_be    = !issue ? '0 : (pick_d ? bus.d_be : '1);

    assign bus.if_gnt    = issue && bus.mem_gnt && !pick_d;
    assign bus.d_gnt     = issue && bus.mem_gnt && pick_d;

    assign bus.if_rvalid = waiting && bus.mem_rvalid && (owner == OWN_IF);
    assign bus.d_rvalid  = waiting && bus.mem_rvalid && (owner == OWN_D);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.arb_err   = arb_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            streak    <= '0;
            arb_err_q <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // A response with nothing outstanding is dropped and flagged.
                    if (bus.mem_rvalid) arb_err_q <= 1'b1;
                    if (issue && bus.mem_gnt) begin
                        owner <= pick_owner;
                        state <= ARB_WAIT;
                        if (pick_d && bus.if_req)
                            streak <= starve ? streak : streak + SW'(1);
                        else
                            streak <= '0;
                    end
                end
                ARB_WAIT: begin
                    if (bus.mem_rvalid) state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expected responses queued at grant, popped at rvalid.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        arb_owner_e  owner;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one memory response in the current cycle and score it against the queue head.
    task automatic respond(input string tag, input logic [31:0] data);
        exp_t e;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb: observed response expected none queued", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_dvld"},  32'(bus.d_rvalid),  32'(e.owner == OWN_D));
            chk({tag, "_ivld"},  32'(bus.if_rvalid), 32'(e.owner == OWN_IF));
            chk({tag, "_rdata"}, (e.owner == OWN_D) ? bus.d_rdata : bus.if_rdata, e.data);
            chk({tag, "_wreq"},  32'(bus.mem_req),   32'd0);
        end
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0;  bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

        // 1. Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt",    32'(bus.if_gnt),    32'd0);
        chk("rst_d_gnt",     32'(bus.d_gnt),     32'd0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);
        chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
        chk("rst_arb_err",   32'(bus.arb_err),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        @(negedge clk);
        chk("rel_mem_req", 32'(bus.mem_req), 32'd1);
        chk("rel_d_gnt",   32'(bus.d_gnt),   32'd0);

        // 2. Single load
        @(posedge clk); #1;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        chk("ld_d_gnt",    32'(bus.d_gnt),  32'd1);
        chk("ld_mem_addr", bus.mem_addr,    32'h100);
        chk("ld_mem_we",   32'(bus.mem_we), 32'd0);
        sb.push_back('{OWN_D, 32'hDEADBEEF});
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        @(negedge clk);
        chk("wait_if_gnt",  32'(bus.if_gnt),  32'd0);
        chk("wait_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.mem_gnt = 1'b0;
        @(posedge clk); #1;
        respond("ld", 32'hDEADBEEF);

        // 3. Contention: D,D,D,D,IF,D
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.d_req = 1'b1;  bus.d_addr = 32'h300; bus.d_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.mem_gnt = 1'b1;
            @(negedge clk);
            chk($sformatf("ct%0d_d_gnt", i),  32'(bus.d_gnt),  32'(exp_d[i]));
            chk($sformatf("ct%0d_if_gnt", i), 32'(bus.if_gnt), 32'(!exp_d[i]));
            chk($sformatf("ct%0d_addr", i),   bus.mem_addr,    exp_d[i] ? 32'h300 : 32'h200);
            sb.push_back('{exp_d[i] ? OWN_D : OWN_IF, 32'hA000_0000 + 32'(i)});
            @(posedge clk); #1;
            bus.mem_gnt = 1'b0;
            respond($sformatf("ct%0d", i), 32'hA000_0000 + 32'(i));
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;

        // 4. Store
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80;
        bus.d_be = 4'b0011; bus.d_wdata = 32'h1234; bus.mem_gnt = 1'b1;
        @(negedge clk);
        chk("st_d_gnt",  32'(bus.d_gnt),  32'd1);
        chk("st_we",     32'(bus.mem_we), 32'd1);
        chk("st_be",     32'(bus.mem_be), 32'h3);
        chk("st_wdata",  bus.mem_wdata,   32'h1234);
        sb.push_back('{OWN_D, 32'h0});
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_gnt = 1'b0;
        respond("st", 32'h0);
        @(negedge clk);
        chk("idle_addr", bus.mem_addr,    32'h0);
        chk("idle_be",   32'(bus.mem_be), 32'h0);
        chk("idle_we",   32'(bus.mem_we), 32'h0);

        // 5. Backpressure on an IF read
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_req", i),  32'(bus.mem_req), 32'd1);
            chk($sformatf("bp%0d_gnt", i),  32'(bus.if_gnt),  32'd0);
            chk($sformatf("bp%0d_addr", i), bus.mem_addr,     32'h500);
            chk($sformatf("bp%0d_be", i),   32'(bus.mem_be),  32'hF);
            @(posedge clk); #1;
        end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        chk("bp_gnt6", 32'(bus.if_gnt), 32'd1);
        sb.push_back('{OWN_IF, 32'hCAFEF00D});
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.mem_gnt = 1'b0;
        respond("bp", 32'hCAFEF00D);

        // 6. Reset pulse mid-WAIT, then a stray response
        bus.d_req = 1'b1; bus.d_addr = 32'h600; bus.mem_gnt = 1'b1;
        @(negedge clk);
        chk("er_d_gnt", 32'(bus.d_gnt), 32'd1);
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("er_pre_err", 32'(bus.arb_err), 32'd0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        chk("er_d_rvalid",  32'(bus.d_rvalid),  32'd0);
        chk("er_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("er_err_set", 32'(bus.arb_err), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("er_err_sticky", 32'(bus.arb_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
